// File: rtl/btn_pulse_bank_if.sv
// btn_pulse_bank_if: groups the button inputs and the conditioned outputs of
// btn_pulse_bank into one bundle.
//   btn_in        raw asynchronous button lines (polarity set by the bank)
//   level         debounced state, 1 = pressed
//   press_pulse   one-cycle pulse on accepted press
//   release_pulse one-cycle pulse on accepted release
//   rep_pulse     one-cycle auto-repeat pulse while held
//   any_press     OR of press_pulse
// master = the side driving the buttons / consuming pulses, slave = the bank.
interface btn_pulse_bank_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] press_pulse;
    logic [N_CH-1:0] release_pulse;
    logic [N_CH-1:0] rep_pulse;
    logic            any_press;

    modport master (
        output btn_in,
        input  level, press_pulse, release_pulse, rep_pulse, any_press
    );

    modport slave (
        input  btn_in,
        output level, press_pulse, release_pulse, rep_pulse, any_press
    );
endinterface

// File: rtl/btn_pulse_bank.sv
// btn_pulse_bank: multi-channel push-button conditioner. Each channel
// synchronises its raw line (2 flops), debounces it with a stability window of
// DEBOUNCE_CYCLES, and produces press/release pulses plus optional auto-repeat.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    btn_pulse_bank_if.slave (btn_in in; level/pulses/any_press out)

// One button channel. All state is private to the channel.
//   clk, reset   as above
//   btn_i        raw button line
//   level_o      debounced pressed state
//   press_o      press pulse, release_o release pulse, rep_o repeat pulse
module btn_pulse_chan #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rep_o
);
    localparam int   DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    // Raw level meaning "not pressed"; also the synchroniser reset value.
    localparam logic INACT = (ACTIVE_LOW != 0);

    logic            sync1_q, sync2_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            level_q, level_d;
    logic            press_q, release_q;
    logic            p, rise, fall;

    always_comb begin
        p        = sync2_q ^ INACT;
        db_cnt_d = '0;
        level_d  = level_q;
        // Any cycle with p == level leaves the counter at 0 and restarts the window.
        if (p != level_q) begin
            if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Edge events are taken from the toggle itself so the pulse register is
    // high in the cycle right after level changes.
    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q   <= INACT;
            sync2_q   <= INACT;
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= rise;
            release_q <= fall;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

    if (REPEAT_DELAY > 0) begin : g_rep
        localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RC_W = $clog2(RMAX + 1);

        typedef enum logic [1:0] {RELEASED, HELD_WAIT, HELD_REPEAT} rep_state_e;

        rep_state_e      state_q;
        logic [RC_W-1:0] rcnt_q;
        logic            rep_q;

        // The counter holds cycles elapsed since the last press/repeat pulse;
        // seeing N-1 at an edge means N cycles have elapsed after that edge.
        // Release is checked first so an expiring counter on the release
        // cycle cannot emit a pulse.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= RELEASED;
                rcnt_q  <= '0;
                rep_q   <= 1'b0;
            end else begin
                rep_q <= 1'b0;
                case (state_q)
                    RELEASED: begin
                        rcnt_q <= '0;
                        if (rise) state_q <= HELD_WAIT;
                    end
                    HELD_WAIT: begin
                        if (fall) begin
                            state_q <= RELEASED;
                            rcnt_q  <= '0;
                        end else if (rcnt_q == RC_W'(REPEAT_DELAY - 1)) begin
                            state_q <= HELD_REPEAT;
                            rcnt_q  <= '0;
                            rep_q   <= 1'b1;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    HELD_REPEAT: begin
                        if (fall) begin
                            state_q <= RELEASED;
                            rcnt_q  <= '0;
                        end else if (rcnt_q == RC_W'(REPEAT_PERIOD - 1)) begin
                            rcnt_q <= '0;
                            rep_q  <= 1'b1;
                        end else begin
                            rcnt_q <= rcnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= RELEASED;
                        rcnt_q  <= '0;
                    end
                endcase
            end
        end

        assign rep_o = rep_q;
    end else begin : g_norep
        assign rep_o = 1'b0;
    end
endmodule

module btn_pulse_bank #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 0,
    parameter int REPEAT_PERIOD   = 1
) (
    input  logic             clk,
    input  logic             reset,
    btn_pulse_bank_if.slave  bus
);
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_pulse_chan #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .btn_i     (bus.btn_in[i]),
            .level_o   (bus.level[i]),
            .press_o   (bus.press_pulse[i]),
            .release_o (bus.release_pulse[i]),
            .rep_o     (bus.rep_pulse[i])
        );
    end

    assign bus.any_press = |bus.press_pulse;
endmodule
